// File: rtl/baud_pkg.sv
// baud_pkg: shared types and constants for the fractional baud generator.
//   divisor_t - fixed-point divisor at the default 14.4 widths.
//   osCode_e  - oversample code, 0=4x, 1=8x, 2=16x, 3=32x.
//   TxMinInt / RxMinInt - smallest integer part each divider accepts.
//   rxShift() - right-shift that turns the bit divisor into the rx divisor.
package baud_pkg;

  localparam int DefIntWidth = 14;
  localparam int DefFracBits = 4;

  typedef struct packed {
    logic [DefIntWidth-1:0] intPart;
    logic [DefFracBits-1:0] fracPart;
  } divisor_t;

  typedef enum logic [1:0] {
    Os4x  = 2'd0,
    Os8x  = 2'd1,
    Os16x = 2'd2,
    Os32x = 2'd3
  } osCode_e;

  // A tx period below 2 clocks would leave no idle cycle between ticks;
  // rx is allowed to tick every cycle.
  localparam int TxMinInt = 2;
  localparam int RxMinInt = 1;

  // 4x oversampling divides the bit period by 4 (shift 2), 32x by 32 (shift 5).
  function automatic logic [2:0] rxShift(input osCode_e os);
    return {1'b0, os} + 3'd2;
  endfunction

endpackage

// File: rtl/frac_divider.sv
// frac_divider: fractional down-counter. The period averages div clocks,
// where div is IntWidth.FracBits fixed point.
//   clk, nReset - clock and asynchronous active-low reset
//   enable      - run; while low the counter sits at its reload value
//   restart     - reload counter from div, clear accumulator
//   align       - load counter with half a period, clear accumulator
//   div         - divisor; integer part below MinInt is clamped to MinInt.0
//   tick        - one-cycle pulse when the counter reaches zero
module frac_divider
  import baud_pkg::*;
#(
  parameter int IntWidth = 14,
  parameter int FracBits = 4,
  parameter int MinInt = RxMinInt,
  parameter logic [IntWidth+FracBits-1:0] ResetDiv = '0
) (
  input  logic                         clk,
  input  logic                         nReset,
  input  logic                         enable,
  input  logic                         restart,
  input  logic                         align,
  input  logic [IntWidth+FracBits-1:0] div,
  output logic                         tick
);

  localparam int DivW = IntWidth + FracBits;
  localparam logic [IntWidth-1:0] One = IntWidth'(1);
  localparam logic [IntWidth-1:0] MinIntV = IntWidth'(MinInt);
  localparam logic [IntWidth-1:0] ResetIntRaw = ResetDiv[DivW-1:FracBits];
  localparam logic [IntWidth-1:0] ResetInt =
    (ResetIntRaw < MinIntV) ? MinIntV : ResetIntRaw;
  localparam logic [IntWidth-1:0] ResetCount = ResetInt - One;

  logic [IntWidth-1:0] count;
  logic [FracBits-1:0] acc;
  logic [IntWidth-1:0] intRaw, intEff, reloadCount, periodCount, halfInt, alignCount;
  logic [FracBits-1:0] fracEff, accNext;
  logic                carry;

  // Clamp, then work out the next period. A period lasts int clocks plus one
  // when the updated accumulator would overflow again on the next add; so a
  // fresh start (acc=0) always lasts exactly int clocks.
  always_comb begin
    intRaw  = div[DivW-1:FracBits];
    intEff  = intRaw;
    fracEff = div[FracBits-1:0];
    if (intRaw < MinIntV) begin
      intEff  = MinIntV;
      fracEff = '0;
    end
    reloadCount = intEff - One;
    accNext     = acc + fracEff;
    // accNext + fracEff overflows exactly when accNext exceeds ~fracEff.
    carry       = (accNext > ~fracEff);
    periodCount = reloadCount + IntWidth'(carry);
    halfInt     = intEff >> 1;
    alignCount  = (halfInt == '0) ? '0 : (halfInt - One);
  end

  assign tick = enable && (count == '0);

  // Counter and accumulator; align beats restart so an rx start edge wins
  // over a simultaneous bit-boundary re-phase.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      count <= ResetCount;
      acc   <= '0;
    end else if (!enable) begin
      count <= reloadCount;
      acc   <= '0;
    end else if (align) begin
      count <= alignCount;
      acc   <= '0;
    end else if (restart) begin
      count <= reloadCount;
      acc   <= '0;
    end else if (count == '0) begin
      count <= periodCount;
      acc   <= accNext;
    end else begin
      count <= count - One;
    end
  end

endmodule

// File: rtl/frac_baud_gen.sv
// frac_baud_gen: UART baud tick generator with a fractional divisor.
//   clk, nReset - clock and asynchronous active-low reset
//   syncReset   - synchronous reset to the default configuration
//   enable      - run tick generation
//   cfgValid/cfgReady/cfgDiv/cfgOs - configuration handshake; a new
//                 configuration takes effect on the next bit boundary
//   rxSync      - start-edge pulse; moves rx ticks to mid-sample
//   txTick      - one pulse per bit period
//   rxTick      - one pulse per oversample period
module frac_baud_gen
  import baud_pkg::*;
#(
  parameter int IntWidth = 14,
  parameter int FracBits = 4,
  parameter int DefaultDiv = 166667,
  parameter int DefaultOs = 2
) (
  input  logic                         clk,
  input  logic                         nReset,
  input  logic                         syncReset,
  input  logic                         enable,
  input  logic                         cfgValid,
  output logic                         cfgReady,
  input  logic [IntWidth+FracBits-1:0] cfgDiv,
  input  logic [1:0]                   cfgOs,
  input  logic                         rxSync,
  output logic                         txTick,
  output logic                         rxTick
);

  localparam int DivW = IntWidth + FracBits;
  localparam logic [DivW-1:0] DefDivV = DivW'(DefaultDiv);
  localparam osCode_e DefOsV = osCode_e'(2'(DefaultOs));
  localparam logic [DivW-1:0] DefRxDivV = DefDivV >> rxShift(DefOsV);

  logic [DivW-1:0] divReg, pendDiv, effDiv, rxDiv;
  osCode_e         osReg, pendOs, effOs;
  logic            pending, accept, apply;
  logic            txRestart, rxRestart, rxAlign;

  assign cfgReady  = !pending;
  assign accept    = cfgValid && cfgReady;
  assign apply     = pending && (txTick || !enable);
  assign txRestart = syncReset || apply;
  assign rxRestart = txRestart || txTick;
  assign rxAlign   = rxSync && !syncReset;

  // The dividers see the configuration that will be live next cycle, so a
  // restart on apply or syncReset reloads from the new values right away.
  always_comb begin
    effDiv = divReg;
    effOs  = osReg;
    if (syncReset) begin
      effDiv = DefDivV;
      effOs  = DefOsV;
    end else if (apply) begin
      effDiv = pendDiv;
      effOs  = pendOs;
    end
    rxDiv = effDiv >> rxShift(effOs);
  end

  // Live configuration plus a single pending slot; offers made while the
  // slot is full are dropped, not queued.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      divReg  <= DefDivV;
      osReg   <= DefOsV;
      pendDiv <= DefDivV;
      pendOs  <= DefOsV;
      pending <= 1'b0;
    end else if (syncReset) begin
      divReg  <= DefDivV;
      osReg   <= DefOsV;
      pendDiv <= DefDivV;
      pendOs  <= DefOsV;
      pending <= 1'b0;
    end else begin
      if (apply) begin
        divReg  <= pendDiv;
        osReg   <= pendOs;
        pending <= 1'b0;
      end
      if (accept) begin
        pendDiv <= cfgDiv;
        pendOs  <= osCode_e'(cfgOs);
        pending <= 1'b1;
      end
    end
  end

  frac_divider #(
    .IntWidth(IntWidth),
    .FracBits(FracBits),
    .MinInt  (TxMinInt),
    .ResetDiv(DefDivV)
  ) txDiv (
    .clk    (clk),
    .nReset (nReset),
    .enable (enable),
    .restart(txRestart),
    .align  (1'b0),
    .div    (effDiv),
    .tick   (txTick)
  );

  frac_divider #(
    .IntWidth(IntWidth),
    .FracBits(FracBits),
    .MinInt  (RxMinInt),
    .ResetDiv(DefRxDivV)
  ) rxDivider (
    .clk    (clk),
    .nReset (nReset),
    .enable (enable),
    .restart(rxRestart),
    .align  (rxAlign),
    .div    (rxDiv),
    .tick   (rxTick)
  );

endmodule

// File: tb/tb_frac_baud_gen.sv
// tb_frac_baud_gen: directed bench for frac_baud_gen with a vector table
// for steady-state periods and hand-written sequences for handshake,
// rxSync, syncReset and asynchronous reset.
module tb_frac_baud_gen;

  localparam int IntW = 14;
  localparam int FracW = 4;

  logic              clk;
  logic              nReset;
  logic              syncReset;
  logic              enable;
  logic              cfgValid;
  logic              cfgReady;
  logic [IntW+FracW-1:0] cfgDiv;
  logic [1:0]        cfgOs;
  logic              rxSync;
  logic              txTick;
  logic              rxTick;

  int checksRun;
  int checksPassed;

  typedef struct packed {
    int div;
    int os;
    int p0;
    int p1;
    int p2;
    int p3;
    int rxFirst;
  } vec_t;

  vec_t vecs[6];

  frac_baud_gen #(
    .IntWidth  (IntW),
    .FracBits  (FracW),
    .DefaultDiv(166667),
    .DefaultOs (2)
  ) dut (
    .clk      (clk),
    .nReset   (nReset),
    .syncReset(syncReset),
    .enable   (enable),
    .cfgValid (cfgValid),
    .cfgReady (cfgReady),
    .cfgDiv   (cfgDiv),
    .cfgOs    (cfgOs),
    .rxSync   (rxSync),
    .txTick   (txTick),
    .rxTick   (rxTick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checksRun++;
    if (actual == expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Program a configuration while disabled; it is accepted at the first
  // edge and applied at the second.
  task automatic applyStimulus(input int div, input int os);
    enable   = 1'b0;
    cfgValid = 1'b0;
    nextCycle();
    cfgDiv   = 18'(div);
    cfgOs    = 2'(os);
    cfgValid = 1'b1;
    nextCycle();
    cfgValid = 1'b0;
    nextCycle();
    nextCycle();
  endtask

  // Cycles advanced until the chosen tick is seen; -1 when the bound expires.
  task automatic waitTick(input bit useTx, input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      nextCycle();
      if ((useTx && txTick) || (!useTx && rxTick)) begin
        cycles = i;
        break;
      end
    end
  endtask

  // Enable and record the cycle numbers of the first five txTicks, counting
  // the first enabled cycle as 1, plus rxTicks up to the first txTick.
  task automatic runVector(input vec_t v, input int idx);
    int t[5];
    int nTx;
    int nRx;
    int n;
    for (int k = 0; k < 5; k++) t[k] = 0;
    nTx = 0;
    nRx = 0;
    n   = 1;
    enable = 1'b1;
    #1;
    while (nTx < 5 && n <= 3000) begin
      if (rxTick && nTx == 0) nRx++;
      if (txTick) begin
        t[nTx] = n;
        nTx++;
      end
      if (nTx < 5) begin
        nextCycle();
        n++;
      end
    end
    checkOutput($sformatf("vec%0d.txPeriod0", idx), t[0], v.p0);
    checkOutput($sformatf("vec%0d.txPeriod1", idx), t[1] - t[0], v.p1);
    checkOutput($sformatf("vec%0d.txPeriod2", idx), t[2] - t[1], v.p2);
    checkOutput($sformatf("vec%0d.txPeriod3", idx), t[3] - t[2], v.p3);
    checkOutput($sformatf("vec%0d.rxFirstPeriod", idx), nRx, v.rxFirst);
  endtask

  initial begin
    int c;
    checksRun    = 0;
    checksPassed = 0;
    nReset    = 1'b0;
    syncReset = 1'b0;
    enable    = 1'b0;
    cfgValid  = 1'b0;
    cfgDiv    = '0;
    cfgOs     = '0;
    rxSync    = 1'b0;

    //           div   os  p0   p1   p2   p3  rxFirst
    vecs[0] = '{ 160,  0,  10,  10,  10,  10,  4 };
    vecs[1] = '{ 168,  0,  10,  11,  10,  11,  4 };
    vecs[2] = '{ 16,   3,  2,   2,   2,   2,   2 };
    vecs[3] = '{ 2560, 2,  160, 160, 160, 160, 16 };
    vecs[4] = '{ 20,   0,  2,   2,   2,   2,   2 };
    vecs[5] = '{ 56,   1,  3,   4,   3,   4,   3 };

    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetTxTick", int'(txTick), 0);
    checkOutput("resetRxTick", int'(rxTick), 0);
    checkOutput("resetCfgReady", int'(cfgReady), 1);
    nReset = 1'b1;
    nextCycle();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].div, vecs[i].os);
      runVector(vecs[i], i);
    end

    // Reconfigure while running: 10.0 -> 20.0 offered 3 cycles after a tick.
    applyStimulus(160, 0);
    enable = 1'b1;
    #1;
    waitTick(1'b1, 100, c);
    checkOutput("hsFirstTx", c, 9);
    nextCycle();
    nextCycle();
    nextCycle();
    cfgDiv   = 18'(320);
    cfgOs    = 2'd0;
    cfgValid = 1'b1;
    #1;
    checkOutput("hsReadyBefore", int'(cfgReady), 1);
    nextCycle();
    cfgValid = 1'b0;
    #1;
    checkOutput("hsReadyDrop", int'(cfgReady), 0);
    nextCycle();
    cfgDiv   = 18'(480);
    cfgValid = 1'b1;
    nextCycle();
    cfgValid = 1'b0;
    waitTick(1'b1, 100, c);
    checkOutput("hsTxBeforeApply", c, 4);
    checkOutput("hsReadyAtApply", int'(cfgReady), 0);
    nextCycle();
    checkOutput("hsReadyAfterApply", int'(cfgReady), 1);
    waitTick(1'b1, 100, c);
    checkOutput("hsNewPeriod", c, 19);
    waitTick(1'b1, 100, c);
    checkOutput("hsNotQueued", c, 20);

    // rxSync at 16x on a 160.0 bit: rx tick 5 cycles later, then every 10.
    applyStimulus(2560, 2);
    enable = 1'b1;
    #1;
    waitTick(1'b1, 400, c);
    checkOutput("syncFirstTx", c, 159);
    nextCycle();
    nextCycle();
    nextCycle();
    rxSync = 1'b1;
    nextCycle();
    rxSync = 1'b0;
    waitTick(1'b0, 50, c);
    checkOutput("rxSyncDelay", (c < 0) ? -1 : c + 1, 5);
    waitTick(1'b0, 50, c);
    checkOutput("rxAfterSync", c, 10);

    // syncReset with a configuration pending: defaults return, pending dropped.
    applyStimulus(160, 0);
    enable = 1'b1;
    #1;
    nextCycle();
    nextCycle();
    cfgDiv   = 18'(320);
    cfgOs    = 2'd0;
    cfgValid = 1'b1;
    nextCycle();
    cfgValid = 1'b0;
    #1;
    checkOutput("srPending", int'(cfgReady), 0);
    syncReset = 1'b1;
    nextCycle();
    syncReset = 1'b0;
    #1;
    checkOutput("srReady", int'(cfgReady), 1);
    checkOutput("srTxTick", int'(txTick), 0);
    waitTick(1'b1, 11000, c);
    checkOutput("srDefaultFirst", c, 10415);
    waitTick(1'b1, 11000, c);
    checkOutput("srDefaultSecond", c, 10417);

    // Asynchronous reset in the middle of a tick cycle.
    applyStimulus(16, 3);
    enable = 1'b1;
    #1;
    nextCycle();
    checkOutput("arTickBefore", int'(txTick), 1);
    #3;
    nReset = 1'b0;
    #1;
    checkOutput("arTxTick", int'(txTick), 0);
    checkOutput("arRxTick", int'(rxTick), 0);
    checkOutput("arCfgReady", int'(cfgReady), 1);
    #2;
    nReset = 1'b1;
    nextCycle();

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule
